// File: rtl/mem_responder_if.sv
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/response bus between a CPU load/store port and its memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Multi-cycle data memory responder, one transaction outstanding.
//            MEM_RESP_BOUNDS_EN: flag word indices >= DEPTH as errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic        r_busy;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_commit;
  logic          w_cur_we;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic [AW-1:0] w_idx;
  logic          w_err;

  assign w_accept = bus.req_valid & r_req_ready;

  // With zero latency the commit coincides with acceptance, so use the live inputs.
  assign w_cur_we    = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
  assign w_idx       = w_cur_addr[AW+1:2];

`ifdef MEM_RESP_BOUNDS_EN
  assign w_err = (w_cur_addr[1:0] != 2'b00) ||
                 ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH));
`else
  logic w_unused_upper;
  assign w_unused_upper = ^w_cur_addr[31:AW+2];
  assign w_err          = (w_cur_addr[1:0] != 2'b00);
`endif

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) w_next_state = S_RESP;
          else              w_next_state = S_WAIT;
        end
      end
      S_WAIT: if (r_cnt == 4'd1) w_next_state = S_RESP;
      S_RESP: if (bus.resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_commit = (w_next_state == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_req_ready  <= (w_next_state == S_IDLE);
      r_resp_valid <= (w_next_state == S_RESP);
      r_busy       <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_cur_we && !w_err) ? r_mem[w_idx] : 32'd0;
      end else if (w_next_state != S_RESP) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= 32'd0;
      end
    end
  end

  // Storage is not reset; a reset on the commit edge must still block the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_cur_we && !w_err) begin
      r_mem[w_idx] <= w_cur_wdata;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Randomized scoreboard bench for mem_responder (plus a zero-latency instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   rr_rand = 1'b0;

  logic [31:0] ref_mem [DEPTH];
  exp_t        sbq [$];
  exp_t        cur;
  bit          prev_v = 1'b0;
  bit          prev_hs = 1'b0;

  mem_responder_if bus  ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: misaligned (and optionally out-of-range) requests error; index wraps.
  function automatic void model(bit we, logic [31:0] a, logic [31:0] d, int t);
    exp_t e;
    int   idx;
    bit   err;
    err = (a[1:0] != 2'b00);
`ifdef MEM_RESP_BOUNDS_EN
    if ((a >> 2) >= DEPTH) err = 1'b1;
`endif
    idx     = int'((a >> 2) % DEPTH);
    e.err   = err;
    e.rdata = (!we && !err) ? ref_mem[idx] : 32'd0;
    e.t     = t;
    if (we && !err) ref_mem[idx] = d;
    sbq.push_back(e);
  endfunction

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input bit track);
    int g = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (!bus.req_ready) begin
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    if (track) model(we, a, d, cyc);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic set_rr(input bit v);
    rr_rand = 1'b0;
    @(posedge clk);
    #1 bus.resp_ready = v;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sbq.size() != 0 || bus.busy !== 1'b0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (g >= 500) begin
      fails++;
      $display("FAIL idle_timeout: %0d responses still pending, expected 0", sbq.size());
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [31:0] a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (sel == 1) a = a + 32'h100 * 32'($urandom_range(1, 8));
    return a;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops an expectation at the first cycle of each response.
  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk1("post_hs_resp_valid", bus.resp_valid, 1'b0);
        chk1("post_hs_req_ready", bus.req_ready, 1'b1);
      end
      if (bus.resp_valid) begin
        if (!prev_v) begin
          tests++;
          if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_resp: resp_valid=1, expected no response");
          end else begin
            cur = sbq.pop_front();
            chk32("latency", 32'(cyc - cur.t), 32'(LAT + 1));
            chk32("resp_rdata", bus.resp_rdata, cur.rdata);
            chk1("resp_err", bus.resp_err, cur.err);
          end
        end else begin
          chk32("hold_rdata", bus.resp_rdata, cur.rdata);
          chk1("hold_err", bus.resp_err, cur.err);
        end
        chk1("resp_req_ready", bus.req_ready, 1'b0);
        chk1("resp_busy", bus.busy, 1'b1);
      end
      prev_v  = bus.resp_valid;
      prev_hs = bus.resp_valid && bus.resp_ready;
    end
  end

  initial begin
    int g;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = 32'd0;
    bus.req_wdata   = 32'd0;
    bus.resp_ready  = 1'b1;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_addr   = 32'd0;
    bus0.req_wdata  = 32'd0;
    bus0.resp_ready = 1'b1;

    // Reset: two cycles high, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk32("rst_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_req_ready", bus.req_ready, 1'b1);
    chk1("post_rst_busy", bus.busy, 1'b0);

    // Zero-latency instance: response next cycle, ready returns the cycle after.
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1;
    bus0.req_addr = 32'h8; bus0.req_wdata = 32'h0000_A5A5;
    @(negedge clk);
    chk1("l0_st_valid", bus0.resp_valid, 1'b1);
    chk1("l0_st_ready", bus0.req_ready, 1'b0);
    chk32("l0_st_rdata", bus0.resp_rdata, 32'd0);
    bus0.req_valid = 1'b0;
    @(negedge clk);
    chk1("l0_idle_valid", bus0.resp_valid, 1'b0);
    chk1("l0_idle_ready", bus0.req_ready, 1'b1);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0;
    @(negedge clk);
    chk1("l0_ld_valid", bus0.resp_valid, 1'b1);
    chk32("l0_ld_rdata", bus0.resp_rdata, 32'h0000_A5A5);
    chk1("l0_ld_err", bus0.resp_err, 1'b0);
    bus0.req_valid = 1'b0;
    @(negedge clk);
    chk1("l0_ld_ready", bus0.req_ready, 1'b1);

    // Store then load at 0x10 with resp_ready high.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    wait_idle();

    // Fill every word so later loads have known contents.
    rr_rand = 1'b1;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);
    wait_idle();

    // Misaligned store is dropped; range check on 0x100.
    issue(1'b1, 32'h13, 32'h1, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 32'h100, 32'h0, 1'b1);
    wait_idle();

    // Backpressure: resp_ready low for 5 cycles in RESP.
    set_rr(1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    g = 0;
    while (!bus.resp_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    chk1("bp_hold_valid", bus.resp_valid, 1'b1);
    set_rr(1'b1);
    wait_idle();

    // Reset during the first WAIT cycle aborts the store.
    issue(1'b1, 32'h20, 32'h55, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_valid", bus.resp_valid, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 1'b1);
    wait_idle();

    // Randomized traffic with random backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) issue(1'($urandom), rand_addr(), $urandom, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
